// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
package hazard_forward_unit_pkg;

    // Forward-select encoding; a stage k >= 1 entry forwards with select k+1,
    // so deeper trackers continue the numbering past FWD_WB.
    localparam int FWD_RF  = 0;
    localparam int FWD_EXE = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    // Width of the saturating stall-cycle counter.
    localparam int STALL_CNT_W = 16;

    // Control part of one tracked in-flight instruction. The destination index
    // and data payload depend on module parameters, so they are kept in
    // parallel arrays indexed the same way as these flags.
    typedef struct packed {
        logic valid;
        logic wrt_en;
        logic is_load;
        logic ready;
    } entry_flags_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_source_lookup.sv
// Priority lookup of one decode source operand against the in-flight tracker.
module fwd_source_lookup
    import hazard_forward_unit_pkg::*;
#(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DEPTH               = 3,
    parameter int SEL_BITS            = $clog2(DEPTH + 1)
) (
    input  logic                           src_used,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src_index,
    input  entry_flags_t                   flags [DEPTH],
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dst [DEPTH],
    input  logic [DBITS-1:0]               data [DEPTH],
    input  logic [DBITS-1:0]               exe_result,
    input  logic [DBITS-1:0]               mem_result,
    output logic [SEL_BITS-1:0]            sel,
    output logic [DBITS-1:0]               fwd_data,
    output logic                           load_use
);

    logic found;

    // Youngest matching writer wins; a load still in EXE cannot forward and flags a load-use hazard.
    always_comb begin
        sel      = SEL_BITS'(FWD_RF);
        fwd_data = '0;
        load_use = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && src_used && flags[k].valid && flags[k].wrt_en && (dst[k] == src_index)) begin
                found = 1'b1;
                if (k == 0) begin
                    if (flags[k].is_load) begin
                        load_use = 1'b1;
                    end else begin
                        sel      = SEL_BITS'(FWD_EXE);
                        fwd_data = exe_result;
                    end
                end else if (flags[k].ready) begin
                    sel      = SEL_BITS'(k + 1);
                    fwd_data = data[k];
                end else begin
                    sel      = SEL_BITS'(FWD_MEM);
                    fwd_data = mem_result;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and operand bypass selection for an in-order pipeline.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DEPTH               = 3,
    parameter int SEL_BITS            = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           advance_en,
    input  logic                           issue_valid,
    input  logic                           issue_wrt_en,
    input  logic                           issue_is_load,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] issue_dst,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src1_index,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src2_index,
    input  logic                           src1_used,
    input  logic                           src2_used,
    input  logic [DBITS-1:0]               exe_result,
    input  logic [DBITS-1:0]               mem_result,
    input  logic                           flush,
    output logic                           stall,
    output logic [SEL_BITS-1:0]            fwd1_sel,
    output logic [SEL_BITS-1:0]            fwd2_sel,
    output logic [DBITS-1:0]               fwd1_data,
    output logic [DBITS-1:0]               fwd2_data,
    output logic [STALL_CNT_W-1:0]         stall_cycles
);

    entry_flags_t                   flags_q [DEPTH];
    entry_flags_t                   flags_d [DEPTH];
    logic [REG_INDEX_BIT_WIDTH-1:0] dst_q   [DEPTH];
    logic [REG_INDEX_BIT_WIDTH-1:0] dst_d   [DEPTH];
    logic [DBITS-1:0]               data_q  [DEPTH];
    logic [DBITS-1:0]               data_d  [DEPTH];
    logic [STALL_CNT_W-1:0]         stall_cycles_q;
    logic [STALL_CNT_W-1:0]         stall_cycles_d;
    logic                           load_use1;
    logic                           load_use2;

    fwd_source_lookup #(
        .DBITS              (DBITS),
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
        .DEPTH              (DEPTH),
        .SEL_BITS           (SEL_BITS)
    ) u_lookup_src1 (
        .src_used  (src1_used),
        .src_index (src1_index),
        .flags     (flags_q),
        .dst       (dst_q),
        .data      (data_q),
        .exe_result(exe_result),
        .mem_result(mem_result),
        .sel       (fwd1_sel),
        .fwd_data  (fwd1_data),
        .load_use  (load_use1)
    );

    fwd_source_lookup #(
        .DBITS              (DBITS),
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
        .DEPTH              (DEPTH),
        .SEL_BITS           (SEL_BITS)
    ) u_lookup_src2 (
        .src_used  (src2_used),
        .src_index (src2_index),
        .flags     (flags_q),
        .dst       (dst_q),
        .data      (data_q),
        .exe_result(exe_result),
        .mem_result(mem_result),
        .sel       (fwd2_sel),
        .fwd_data  (fwd2_data),
        .load_use  (load_use2)
    );

    // A flushed or empty decode slot never stalls, so flush overrides a load-use hazard.
    always_comb begin
        stall = (load_use1 | load_use2) & issue_valid & ~flush;
    end

    // Next tracker contents: shift one stage per advance, capturing results as entries leave EXE and MEM.
    always_comb begin
        flags_d = flags_q;
        dst_d   = dst_q;
        data_d  = data_q;
        if (advance_en) begin
            if (issue_valid && !stall && !flush) begin
                flags_d[0].valid   = 1'b1;
                flags_d[0].wrt_en  = issue_wrt_en;
                flags_d[0].is_load = issue_is_load;
                flags_d[0].ready   = 1'b0;
                dst_d[0]           = issue_dst;
            end else begin
                flags_d[0] = '0;
                dst_d[0]   = '0;
            end
            data_d[0] = '0;

            flags_d[1]       = flags_q[0];
            flags_d[1].ready = ~flags_q[0].is_load;
            dst_d[1]         = dst_q[0];
            data_d[1]        = exe_result;

            for (int k = 2; k < DEPTH; k++) begin
                flags_d[k] = flags_q[k-1];
                dst_d[k]   = dst_q[k-1];
                data_d[k]  = data_q[k-1];
                if ((k == 2) && !flags_q[1].ready) begin
                    flags_d[k].ready = 1'b1;
                    data_d[k]        = mem_result;
                end
            end
        end
    end

    // Stall counter advances only on cycles the pipeline actually spends stalled, and sticks at all-ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (advance_en && stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // Tracker and counter state; reset is active-low and discards every in-flight entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                flags_q[k] <= '0;
                dst_q[k]   <= '0;
                data_q[k]  <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            flags_q        <= flags_d;
            dst_q          <= dst_d;
            data_q         <= data_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed vector table plus multi-cycle sequences.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance_en;
    logic        issue_valid;
    logic        issue_wrt_en;
    logic        issue_is_load;
    logic [3:0]  issue_dst;
    logic [3:0]  src1_index;
    logic [3:0]  src2_index;
    logic        src1_used;
    logic        src2_used;
    logic [31:0] exe_result;
    logic [31:0] mem_result;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd1_sel;
    logic [1:0]  fwd2_sel;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [15:0] stall_cycles;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        iv;
        logic        we;
        logic        ld;
        logic [3:0]  dst;
        logic [3:0]  s1;
        logic        u1;
        logic [3:0]  s2;
        logic        u2;
        logic [31:0] exe;
        logic [31:0] mem;
        logic        fl;
        logic        e_stall;
        logic [1:0]  e_sel1;
        logic [31:0] e_d1;
        logic [1:0]  e_sel2;
        logic [31:0] e_d2;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .DBITS              (32),
        .REG_INDEX_BIT_WIDTH(4),
        .DEPTH              (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .advance_en   (advance_en),
        .issue_valid  (issue_valid),
        .issue_wrt_en (issue_wrt_en),
        .issue_is_load(issue_is_load),
        .issue_dst    (issue_dst),
        .src1_index   (src1_index),
        .src2_index   (src2_index),
        .src1_used    (src1_used),
        .src2_used    (src2_used),
        .exe_result   (exe_result),
        .mem_result   (mem_result),
        .flush        (flush),
        .stall        (stall),
        .fwd1_sel     (fwd1_sel),
        .fwd2_sel     (fwd2_sel),
        .fwd1_data    (fwd1_data),
        .fwd2_data    (fwd2_data),
        .stall_cycles (stall_cycles)
    );

    task automatic applyStimulus(input logic iv, input logic we, input logic ld, input logic [3:0] dst,
                                 input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic u2,
                                 input logic [31:0] exe, input logic [31:0] mem, input logic fl, input logic adv);
        issue_valid   = iv;
        issue_wrt_en  = we;
        issue_is_load = ld;
        issue_dst     = dst;
        src1_index    = s1;
        src1_used     = u1;
        src2_index    = s2;
        src2_used     = u2;
        exe_result    = exe;
        mem_result    = mem;
        flush         = fl;
        advance_en    = adv;
    endtask

    task automatic compareField(input string name, input string field, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_stall, input logic [1:0] e_sel1, input logic [31:0] e_d1,
                               input logic [1:0] e_sel2, input logic [31:0] e_d2, input logic [15:0] e_cnt);
        compareField(name, "stall",        {31'd0, stall},   {31'd0, e_stall});
        compareField(name, "fwd1_sel",     {30'd0, fwd1_sel}, {30'd0, e_sel1});
        compareField(name, "fwd1_data",    fwd1_data,         e_d1);
        compareField(name, "fwd2_sel",     {30'd0, fwd2_sel}, {30'd0, e_sel2});
        compareField(name, "fwd2_data",    fwd2_data,         e_d2);
        compareField(name, "stall_cycles", {16'd0, stall_cycles}, {16'd0, e_cnt});
    endtask

    initial begin
        vec_t        v;
        logic [15:0] cnt_exp;

        // {iv,we,ld,dst, s1,u1,s2,u2, exe,mem,flush | stall,sel1,d1,sel2,d2,cnt}
        vecs[0]  = '{1'b0,1'b0,1'b0,4'd0,  4'd0,1'b0,4'd0,1'b0,  32'h0,32'h0,1'b0,          1'b0,2'd0,32'h0,2'd0,32'h0,16'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,4'd3,  4'd1,1'b1,4'd2,1'b1,  32'h11,32'h0,1'b0,         1'b0,2'd0,32'h0,2'd0,32'h0,16'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,4'd7,  4'd3,1'b1,4'd3,1'b0,  32'h7,32'h0,1'b0,          1'b0,2'd1,32'h7,2'd0,32'h0,16'd0};
        vecs[3]  = '{1'b1,1'b1,1'b1,4'd5,  4'd3,1'b1,4'd7,1'b1,  32'h20,32'h0,1'b0,         1'b0,2'd2,32'h7,2'd1,32'h20,16'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,4'd8,  4'd3,1'b1,4'd5,1'b1,  32'h100,32'h0,1'b0,        1'b1,2'd3,32'h7,2'd0,32'h0,16'd0};
        vecs[5]  = '{1'b1,1'b1,1'b0,4'd8,  4'd3,1'b1,4'd5,1'b1,  32'h55,32'hDEADBEEF,1'b0,  1'b0,2'd0,32'h0,2'd2,32'hDEADBEEF,16'd1};
        vecs[6]  = '{1'b1,1'b1,1'b0,4'd2,  4'd5,1'b1,4'd8,1'b1,  32'h88,32'h0,1'b0,         1'b0,2'd3,32'hDEADBEEF,2'd1,32'h88,16'd1};
        vecs[7]  = '{1'b1,1'b1,1'b0,4'd2,  4'd0,1'b0,4'd0,1'b0,  32'h22,32'h0,1'b0,         1'b0,2'd0,32'h0,2'd0,32'h0,16'd1};
        vecs[8]  = '{1'b1,1'b1,1'b0,4'd9,  4'd0,1'b0,4'd0,1'b0,  32'h33,32'h0,1'b0,         1'b0,2'd0,32'h0,2'd0,32'h0,16'd1};
        vecs[9]  = '{1'b1,1'b1,1'b0,4'd2,  4'd0,1'b0,4'd0,1'b0,  32'h44,32'h0,1'b0,         1'b0,2'd0,32'h0,2'd0,32'h0,16'd1};
        vecs[10] = '{1'b1,1'b0,1'b0,4'd0,  4'd2,1'b1,4'd9,1'b1,  32'h99,32'h0,1'b0,         1'b0,2'd1,32'h99,2'd2,32'h44,16'd1};
        vecs[11] = '{1'b1,1'b1,1'b1,4'd0,  4'd0,1'b1,4'd2,1'b1,  32'h1234,32'h0,1'b0,       1'b0,2'd0,32'h0,2'd2,32'h99,16'd1};
        vecs[12] = '{1'b1,1'b1,1'b0,4'd10, 4'd0,1'b1,4'd0,1'b0,  32'h5,32'h0,1'b1,          1'b0,2'd0,32'h0,2'd0,32'h0,16'd1};
        vecs[13] = '{1'b1,1'b0,1'b0,4'd0,  4'd0,1'b1,4'd10,1'b1, 32'h6,32'hCAFE0000,1'b0,   1'b0,2'd2,32'hCAFE0000,2'd0,32'h0,16'd1};
        vecs[14] = '{1'b1,1'b0,1'b0,4'd0,  4'd0,1'b1,4'd0,1'b1,  32'h7,32'h0,1'b0,          1'b0,2'd3,32'hCAFE0000,2'd3,32'hCAFE0000,16'd1};

        // Outputs must be quiet while reset is held, before any clock edge
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("in_reset", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table, one pipeline cycle per record
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            v = vecs[i];
            applyStimulus(v.iv, v.we, v.ld, v.dst, v.s1, v.u1, v.s2, v.u2, v.exe, v.mem, v.fl, 1'b1);
            #2;
            checkOutput($sformatf("vec%0d", i), v.e_stall, v.e_sel1, v.e_d1, v.e_sel2, v.e_d2, v.e_cnt);
        end

        // Freeze with an ALU write to r4 sitting at stage 1
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("freeze_issue", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'h4444, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b1, 4'd0, 1'b0, 32'h9999, 32'h7777, 1'b0, 1'b0);
            #2;
            checkOutput($sformatf("freeze_hold%0d", i), 1'b0, 2'd2, 32'h4444, 2'd0, 32'h0, 16'd1);
        end

        // Load-use while frozen: stall visible but counter must not move until the pipeline advances
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
            #2;
            checkOutput($sformatf("frozen_stall%0d", i), 1'b1, 2'd0, 32'h0, 2'd0, 32'h0, 16'd1);
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("live_stall", 1'b1, 2'd0, 32'h0, 2'd0, 32'h0, 16'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("live_stall_count", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'd2);

        // Preload the counter near its ceiling, then drive three load-use stalls
        @(negedge clk);
        force dut.stall_cycles_d = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.stall_cycles_d;
        #2;
        checkOutput("preload", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'hFFFE);
        cnt_exp = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1, 1'b1, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            #2;
            checkOutput($sformatf("sat_load%0d", i), 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, cnt_exp);
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b1, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            #2;
            checkOutput($sformatf("sat_stall%0d", i), 1'b1, 2'd0, 32'h0, 2'd0, 32'h0, cnt_exp);
            cnt_exp = (cnt_exp == 16'hFFFF) ? cnt_exp : cnt_exp + 16'd1;
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("saturated", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'hFFFF);

        // Reset in the middle of live hazards: everything clears at once and stays cleared
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 32'h4040, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b1, 4'd4, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("pre_reset", 1'b1, 2'd0, 32'h0, 2'd2, 32'h4040, 16'hFFFF);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        checkOutput("post_reset", 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
